ifmap_spad_ctrl: RTL and testbench
==================================

# ifmap_spad_ctrl

Sequencing controller for a PE's ifmap scratchpad, which is a `Buffer` instance with `PAR_WRITE = PAR_READ = 1`. It accepts one row of ifmap elements over a valid/ready stream and writes them circularly into the scratchpad. It then issues one scratchpad read per cycle for each 1-D convolution window, driving the MAC datapath. Occupancy is tracked so unconsumed data is never overwritten, and elements are released as windows slide by `STRIDE`.

## Interface
- `DEPTH`, 8: scratchpad entries. Must be a power of 2 and ≥ `WIN`.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: scratchpad address width.
- `WIN`, 3: filter width, i.e. reads per window. Must be ≥ 1.
- `STRIDE`, 1: window step. Must satisfy 1 ≤ `STRIDE` ≤ `WIN`.
- `LEN_WIDTH`, 8: width of the row length.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  single-cycle row start pulse.
- `row_len`  in  LEN_WIDTH  elements in the row. Sampled on `start`.
- `in_valid`  in  1  ifmap element offered.
- `in_ready`  out  1  element accepted this cycle.
- `buf_write_en`  out  1  equals `in_valid && in_ready`.
- `buf_write_addr`  out  ADDR_WIDTH  scratchpad write address.
- `buf_read_addr`  out  ADDR_WIDTH  scratchpad read address.
- `rd_valid`  out  1  buffer `read_data` is a valid window tap.
- `rd_ready`  in  1  MAC consumes the tap.
- `rd_first`  out  1  tap k = 0 (clear psum).
- `rd_last`  out  1  tap k = `WIN`-1 (psum complete).
- `done`  out  1  single-cycle row completion pulse.
- `cfg_err`  out  1  single-cycle pulse: `start` rejected.

## Operation
- States are IDLE, RUN, FLUSH and DONE.
- Registers:
  - `len`, LEN_WIDTH bits.
  - `in_cnt`, LEN_WIDTH bits: elements accepted.
  - `win_start`, LEN_WIDTH bits: absolute index of the current window.
  - `k`: tap index, width `$clog2(WIN)`, minimum 1.
- IDLE:
  - `start` with `row_len` ≥ `WIN`: latch `len`, clear `in_cnt`, `win_start` and `k`, and go to RUN.
  - `start` with `row_len` < `WIN`: pulse `cfg_err` next cycle and stay in IDLE.
- `start` in any state other than IDLE is ignored.
- Write side, active in RUN and FLUSH:
  - `in_ready = (in_cnt < len) && (in_cnt - win_start < DEPTH)`.
  - `buf_write_addr = in_cnt[ADDR_WIDTH-1:0]`.
  - Each accept increments `in_cnt`.
- Read side, RUN only:
  - `buf_read_addr = (win_start + k)` mod `DEPTH`.
  - `rd_valid = (win_start + k < in_cnt)`, meaning the element was written on an earlier edge.
  - On `rd_valid && rd_ready` with k < `WIN`-1: increment k.
  - On `rd_valid && rd_ready` with k = `WIN`-1: set k to 0, advance `win_start` by `STRIDE`, which releases `STRIDE` entries.
- Last window: the window whose `win_start + STRIDE + WIN > len`. On its final tap handshake:
  - go to DONE if `in_cnt` after this edge equals `len`;
  - otherwise go to FLUSH.
- FLUSH accepts the trailing unused elements. It moves to DONE on the accept that makes `in_cnt = len`.
- DONE asserts `done` for one cycle, then returns to IDLE.
- Arithmetic: compare `win_start + k` and `win_start + STRIDE + WIN` in LEN_WIDTH+1 bits; no truncation is allowed.
- No slot conflict is possible. A write to slot `win_start` mod `DEPTH` requires occupancy `DEPTH`, which forces `in_ready` = 0.

## Timing
- Reset values:
  - state IDLE;
  - all counters 0;
  - `in_ready`, `rd_valid`, `buf_write_en`, `done` and `cfg_err` all 0;
  - addresses 0;
  - `rd_first` = 1 and `rd_last` = (`WIN` = 1), since both are decoded from k.
- Reset asserted mid-row aborts immediately; no `done` is produced.
- Input → earliest tap: an element accepted at edge N can be read as a tap in cycle N+1. Buffer reads are combinational, so the tap data is valid in the same cycle as `rd_valid`.
- Throughput: one tap per cycle when `rd_ready` is held high and the data is present.
- A write and a read may occur in the same cycle.
- A release (final tap of a window) and an accept in the same cycle update occupancy by +1 − `STRIDE`.
- `rd_valid` does not depend on `rd_ready`. `in_ready` does not depend on `in_valid`.
- `done` asserts exactly one cycle after the last of {final tap, final accept}.
- Outputs `cfg_err` and `done` are registered. The others are combinational decodes of registers.

## Structure
- Shared package holds:
  - the state encoding enum (IDLE, RUN, FLUSH, DONE);
  - the default scratchpad depth constant.
- No sub-module. The PE top instantiates `ifmap_spad_ctrl` alongside `Buffer` and wires the `buf_*` ports to it.

## Test plan
- Row read sequence: `DEPTH`=8, `WIN`=3, `STRIDE`=1, `row_len`=5, with `rd_ready` tied high.
  - Required read addresses: 0,1,2 / 1,2,3 / 2,3,4.
  - `rd_first` and `rd_last` mark each triple.
  - `done` asserts once; FLUSH is never entered.
- Stride and trailing data: `STRIDE`=2, `row_len`=6.
  - Required windows start at 0 and 2.
  - Element 5 is accepted in FLUSH.
  - `done` asserts the cycle after that accept.
- Backpressure and occupancy: `DEPTH`=4, `row_len`=10, `rd_ready`=0.
  - `in_ready` drops after 4 accepts.
  - Releasing `rd_ready` gives exactly 1 new accept per completed window.
- Address wrap: `DEPTH`=4, `row_len`=10.
  - `buf_write_addr` sequence is 0,1,2,3,0,1,…
  - Window 3 reads addresses 3,0,1 with the correct data.
- Configuration error: `start` with `row_len`=2 and `WIN`=3.
  - `cfg_err` pulses for one cycle and state stays IDLE.
  - `start` during RUN is ignored.
- Reset mid-operation: drop `rst_n` after 2 windows.
  - All outputs are at reset values immediately.
  - A new `start` runs a full row correctly.

Source files
------------

// File: rtl/ifmap_spad_ctrl_pkg.sv
// ifmap_spad_ctrl_pkg: shared state encoding and default scratchpad depth
package ifmap_spad_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam int DEFAULT_DEPTH = 8;
endpackage

// File: rtl/ifmap_spad_ctrl_if.sv
// ifmap_spad_ctrl_if: row stream, scratchpad address and tap handshake bundle
interface ifmap_spad_ctrl_if
  import ifmap_spad_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(DEFAULT_DEPTH),
  parameter int LEN_WIDTH  = 8
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  row_len;
  logic                  in_valid;
  logic                  in_ready;
  logic                  buf_write_en;
  logic [ADDR_WIDTH-1:0] buf_write_addr;
  logic [ADDR_WIDTH-1:0] buf_read_addr;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_first;
  logic                  rd_last;
  logic                  done;
  logic                  cfg_err;
  modport master (
    output start, row_len, in_valid, rd_ready,
    input  in_ready, buf_write_en, buf_write_addr, buf_read_addr,
           rd_valid, rd_first, rd_last, done, cfg_err
  );
  modport slave (
    input  start, row_len, in_valid, rd_ready,
    output in_ready, buf_write_en, buf_write_addr, buf_read_addr,
           rd_valid, rd_first, rd_last, done, cfg_err
  );
endinterface

// File: rtl/ifmap_spad_ctrl.sv
// ifmap_spad_ctrl: circular ifmap scratchpad writer and sliding-window tap sequencer
module ifmap_spad_ctrl
  import ifmap_spad_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int WIN        = 3,
  parameter int STRIDE     = 1,
  parameter int LEN_WIDTH  = 8
) (
  input logic            clk,
  input logic            rst_n,
  ifmap_spad_ctrl_if.slave bus
);
  localparam int KW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [LEN_WIDTH:0] DEPTH_W  = (LEN_WIDTH+1)'(DEPTH);
  localparam logic [LEN_WIDTH:0] WIN_W    = (LEN_WIDTH+1)'(WIN);
  localparam logic [LEN_WIDTH:0] STRIDE_W = (LEN_WIDTH+1)'(STRIDE);
  localparam logic [KW-1:0]      LAST_K   = KW'(WIN - 1);
  state_t               state;
  logic [LEN_WIDTH-1:0] len, in_cnt, win_start, in_cnt_nxt;
  logic [KW-1:0]        k;
  logic                 done_q, cfg_err_q;
  logic [LEN_WIDTH:0]   tap, occ;
  logic                 in_ready, rd_valid, wr, rd, last_win;
  assign tap        = {1'b0, win_start} + (LEN_WIDTH+1)'(k);
  assign occ        = {1'b0, in_cnt - win_start};
  assign in_ready   = (state == RUN || state == FLUSH) && (in_cnt < len) && (occ < DEPTH_W);
  assign rd_valid   = (state == RUN) && (tap < {1'b0, in_cnt});
  assign wr         = bus.in_valid && in_ready;
  assign rd         = rd_valid && bus.rd_ready;
  assign in_cnt_nxt = in_cnt + LEN_WIDTH'(wr);
  assign last_win   = ({1'b0, win_start} + STRIDE_W + WIN_W) > {1'b0, len};
  assign bus.in_ready       = in_ready;
  assign bus.buf_write_en   = wr;
  assign bus.buf_write_addr = in_cnt[ADDR_WIDTH-1:0];
  assign bus.buf_read_addr  = tap[ADDR_WIDTH-1:0];
  assign bus.rd_valid       = rd_valid;
  assign bus.rd_first       = (k == '0);
  assign bus.rd_last        = (k == LAST_K);
  assign bus.done           = done_q;
  assign bus.cfg_err        = cfg_err_q;
  // row sequencing: accept counting, tap stepping, window release and completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      in_cnt    <= '0;
      win_start <= '0;
      k         <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (wr) in_cnt <= in_cnt_nxt;
      case (state)
        IDLE: if (bus.start) begin
          if ({1'b0, bus.row_len} >= WIN_W) begin
            len       <= bus.row_len;
            in_cnt    <= '0;
            win_start <= '0;
            k         <= '0;
            state     <= RUN;
          end else cfg_err_q <= 1'b1;
        end
        RUN: if (rd) begin
          if (k == LAST_K) begin
            k         <= '0;
            win_start <= win_start + LEN_WIDTH'(STRIDE);
            if (last_win) begin
              state  <= (in_cnt_nxt == len) ? DONE : FLUSH;
              done_q <= (in_cnt_nxt == len);
            end
          end else k <= k + KW'(1);
        end
        FLUSH: if (wr && in_cnt_nxt == len) begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// tb_ifmap_spad_ctrl: directed checks of row sequencing, stride, backpressure, wrap, cfg error and reset
module tb_ifmap_spad_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int   sel = 0;
  logic start_s = 1'b0, rr_s = 1'b0, feed = 1'b0, clr = 1'b0;
  int   lim = 0;
  logic [7:0] row_len = '0;
  logic [2:0] start, iv, rr, iready, wen, rvalid, rfirst, rlast, done, cfg_err;
  logic [2:0][7:0] waddr, raddr;
  int acc_n = 0;
  int mem [8];
  int cyc = 0, done_n = 0, cfg_n = 0, done_cyc = 0, last_tap_cyc = 0, last_acc_cyc = 0;
  int tap_addr [$];
  int tap_data [$];
  int tap_fl [$];
  int wr_addr [$];
  int n_tests = 0, n_fail = 0;
  assign start = start_s ? 3'(1 << sel) : 3'b0;
  assign rr    = rr_s ? 3'(1 << sel) : 3'b0;
  always_comb begin
    iv      = '0;
    iv[sel] = feed && (acc_n < lim);
  end
  // three controllers: base (D8,S1), stride 2 (D8,S2), shallow (D4,S1)
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 2) ? 4 : 8;
    localparam int S = (g == 1) ? 2 : 1;
    ifmap_spad_ctrl_if #(.ADDR_WIDTH($clog2(D)), .LEN_WIDTH(8)) bus ();
    ifmap_spad_ctrl #(.DEPTH(D), .ADDR_WIDTH($clog2(D)), .WIN(3), .STRIDE(S), .LEN_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    assign bus.start    = start[g];
    assign bus.row_len  = row_len;
    assign bus.in_valid = iv[g];
    assign bus.rd_ready = rr[g];
    assign iready[g]    = bus.in_ready;
    assign wen[g]       = bus.buf_write_en;
    assign rvalid[g]    = bus.rd_valid;
    assign rfirst[g]    = bus.rd_first;
    assign rlast[g]     = bus.rd_last;
    assign done[g]      = bus.done;
    assign cfg_err[g]   = bus.cfg_err;
    assign waddr[g]     = 8'(bus.buf_write_addr);
    assign raddr[g]     = 8'(bus.buf_read_addr);
  end
  // scratchpad model: element i carries data 100+i
  always @(posedge clk) begin
    if (clr) acc_n <= 0;
    else if (wen[sel]) begin
      mem[waddr[sel][2:0]] <= 100 + acc_n;
      acc_n <= acc_n + 1;
    end
  end
  // monitor of the selected controller
  always @(negedge clk) begin
    if (clr) begin
      tap_addr.delete(); tap_data.delete(); tap_fl.delete(); wr_addr.delete();
      cyc = 0; done_n = 0; cfg_n = 0; done_cyc = 0; last_tap_cyc = 0; last_acc_cyc = 0;
    end else begin
      cyc++;
      if (rvalid[sel] && rr[sel]) begin
        tap_addr.push_back(int'(raddr[sel]));
        tap_data.push_back(mem[raddr[sel][2:0]]);
        tap_fl.push_back({rfirst[sel], rlast[sel]});
        last_tap_cyc = cyc;
      end
      if (wen[sel]) begin
        wr_addr.push_back(int'(waddr[sel]));
        last_acc_cyc = cyc;
      end
      if (done[sel]) begin
        done_n++;
        done_cyc = cyc;
      end
      if (cfg_err[sel]) cfg_n++;
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear();
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
  endtask
  task automatic go(input int len);
    row_len = 8'(len);
    start_s = 1'b1;
    cycles(1);
    start_s = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int budget);
    int b = 0;
    while (done_n == 0 && b < budget) begin
      cycles(1);
      b++;
    end
    check(tag, int'(done_n > 0), 1);
  endtask
  task automatic wait_taps(input string tag, input int n, input int budget);
    int b = 0;
    while (tap_addr.size() < n && b < budget) begin
      cycles(1);
      b++;
    end
    check(tag, tap_addr.size(), n);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ctrl"}, int'({iready, wen, rvalid, done, cfg_err}), 0);
    check({tag, "_waddr"}, int'(waddr), 0);
    check({tag, "_raddr"}, int'(raddr), 0);
    check({tag, "_first"}, int'(rfirst), 7);
    check({tag, "_last"}, int'(rlast), 0);
  endtask
  // expected taps: window w starts at w*stride, tap k reads element ws+k
  task automatic check_taps(input string tag, input int nwin, input int stride, input int depth);
    check({tag, "_ntaps"}, tap_addr.size(), nwin * 3);
    for (int i = 0; i < tap_addr.size() && i < nwin * 3; i++) begin
      int e;
      e = (i / 3) * stride + (i % 3);
      check($sformatf("%s_addr%0d", tag, i), tap_addr[i], e % depth);
      check($sformatf("%s_data%0d", tag, i), tap_data[i], 100 + e);
      check($sformatf("%s_fl%0d", tag, i), tap_fl[i], ((i % 3 == 0) ? 2 : 0) + ((i % 3 == 2) ? 1 : 0));
    end
  endtask
  initial begin
    cycles(1);
    check_reset("rst0");
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    // row of 5, stride 1, taps never stalled
    sel = 0;
    clear();
    lim = 5; feed = 1'b1; rr_s = 1'b1;
    go(5);
    wait_done("t1_timeout", 40);
    cycles(2);
    check_taps("t1", 3, 1, 8);
    check("t1_done_n", done_n, 1);
    check("t1_done_cyc", done_cyc, last_tap_cyc + 1);
    check("t1_noflush", int'(last_acc_cyc < last_tap_cyc), 1);
    check("t1_idle_ready", int'(iready[0]), 0);
    // stride 2, row of 6, last element held back until the windows finish
    sel = 1;
    clear();
    lim = 5; feed = 1'b1; rr_s = 1'b1;
    go(6);
    wait_taps("t2_timeout_taps", 6, 40);
    cycles(3);
    check("t2_no_done", done_n, 0);
    check("t2_flush_ready", int'(iready[1]), 1);
    check("t2_flush_rv", int'(rvalid[1]), 0);
    check("t2_acc5", wr_addr.size(), 5);
    lim = 6;
    wait_done("t2_timeout", 20);
    cycles(2);
    check_taps("t2", 2, 2, 8);
    check("t2_wr_last", wr_addr[wr_addr.size()-1], 5);
    check("t2_done_cyc", done_cyc, last_acc_cyc + 1);
    check("t2_acc_after_tap", int'(last_acc_cyc > last_tap_cyc), 1);
    check("t2_done_n", done_n, 1);
    // depth 4: fill stalls, each finished window frees one slot
    sel = 2;
    clear();
    lim = 10; feed = 1'b1; rr_s = 1'b0;
    go(10);
    cycles(10);
    check("t3_fill", wr_addr.size(), 4);
    check("t3_full", int'(iready[2]), 0);
    rr_s = 1'b1; cycles(3); rr_s = 1'b0; cycles(3);
    check("t3_win1_acc", wr_addr.size(), 5);
    check("t3_win1_full", int'(iready[2]), 0);
    rr_s = 1'b1; cycles(3); rr_s = 1'b0; cycles(3);
    check("t3_win2_acc", wr_addr.size(), 6);
    rr_s = 1'b1;
    wait_done("t3_timeout", 100);
    cycles(2);
    check_taps("t3", 8, 1, 4);
    check("t3_nwr", wr_addr.size(), 10);
    for (int i = 0; i < wr_addr.size() && i < 10; i++)
      check($sformatf("t3_waddr%0d", i), wr_addr[i], i % 4);
    check("t3_done_n", done_n, 1);
    // short row rejected, then a start mid-row is ignored
    sel = 0;
    clear();
    feed = 1'b0; rr_s = 1'b1;
    go(2);
    check("t4_cfg_hi", int'(cfg_err[0]), 1);
    cycles(1);
    check("t4_cfg_lo", int'(cfg_err[0]), 0);
    check("t4_cfg_n", cfg_n, 1);
    check("t4_idle", int'(iready[0]), 0);
    lim = 2; feed = 1'b1;
    go(5);
    cycles(6);
    check("t4_acc2", wr_addr.size(), 2);
    go(7);
    check("t4_no_cfg", cfg_n, 1);
    lim = 5;
    wait_done("t4_timeout", 40);
    cycles(2);
    check_taps("t4", 3, 1, 8);
    check("t4_done_n", done_n, 1);
    // reset after two windows, then a clean row
    clear();
    lim = 5; feed = 1'b1; rr_s = 1'b1;
    go(5);
    wait_taps("t5_timeout_taps", 6, 40);
    rst_n = 1'b0;
    #1;
    check_reset("t5_rst");
    cycles(2);
    check("t5_no_done", done_n, 0);
    rst_n = 1'b1;
    cycles(1);
    clear();
    go(5);
    wait_done("t5_timeout", 40);
    cycles(2);
    check_taps("t5", 3, 1, 8);
    check("t5_done_n", done_n, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
